i2c_tx_shifter: RTL and testbench

- I2C slave-side transmitter for read transactions. It is the counterpart of the receive path that feeds the DES wrapper.
- Takes 64-bit processed words (e.g. DES output fetched from SRAM) and shifts them out MSB-first on SDA, one byte per I2C byte slot.
- Samples the master's ACK/NACK after each byte.
- Sits between the I2C slave control logic (start/stop detection, address match) and the SDA open-drain pad.

---
 rtl/i2c_tx_shifter_if.sv | 38 +++
 rtl/i2c_tx_shifter.sv | 169 ++++++++++++++++
 tb/tb_i2c_tx_shifter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_tx_shifter_if.sv
// Bus bundle for i2c_tx_shifter: pad inputs, control pulses, word handshake and status.
// Optional tx_count signal present only when TX_BYTE_COUNT_EN is defined.
interface i2c_tx_shifter_if #(
  parameter int unsigned WORD_BYTES = 8
);
  logic                    scl_in;
  logic                    sda_in;
  logic                    start;
  logic                    i2c_stop;
  logic [8*WORD_BYTES-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_load;
  logic                    sda_oe;
  logic                    busy;
  logic                    nack_rcvd;
  logic                    underrun;
`ifdef TX_BYTE_COUNT_EN
  logic [15:0]             tx_count;

  modport slave (
    input  scl_in, sda_in, start, i2c_stop, tx_data, tx_valid,
    output tx_load, sda_oe, busy, nack_rcvd, underrun, tx_count
  );
  modport master (
    output scl_in, sda_in, start, i2c_stop, tx_data, tx_valid,
    input  tx_load, sda_oe, busy, nack_rcvd, underrun, tx_count
  );
`else
  modport slave (
    input  scl_in, sda_in, start, i2c_stop, tx_data, tx_valid,
    output tx_load, sda_oe, busy, nack_rcvd, underrun
  );
  modport master (
    output scl_in, sda_in, start, i2c_stop, tx_data, tx_valid,
    input  tx_load, sda_oe, busy, nack_rcvd, underrun
  );
`endif
endinterface

// File: rtl/i2c_tx_shifter.sv
// I2C slave read-path transmitter: shifts WORD_BYTES-byte words out MSB-first, samples master ACK.
// Define TX_BYTE_COUNT_EN to add a saturating 16-bit count of ACKed bytes (tx_count).
module i2c_tx_shifter #(
  parameter int unsigned WORD_BYTES  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            n_rst,
  i2c_tx_shifter_if.slave bus
);
  localparam int unsigned DW  = 8 * WORD_BYTES;
  localparam int unsigned BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_ACK, S_ACK_END, S_WAIT_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic [DW-1:0]          shift_q, shift_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   nack_q, nack_d;
  logic                   underrun_q, underrun_d;
  logic                   tx_load_c;
  logic                   load_word;
  logic                   scl_s, sda_s, scl_fall, scl_rise;
`ifdef TX_BYTE_COUNT_EN
  logic [15:0]            tx_count_q, tx_count_d;
`endif

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_fall = scl_prev_q & ~scl_s;
  assign scl_rise = ~scl_prev_q & scl_s;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      shift_q    <= '1;
      sda_oe_q   <= 1'b0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      nack_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef TX_BYTE_COUNT_EN
      tx_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      nack_q     <= nack_d;
      underrun_q <= underrun_d;
`ifdef TX_BYTE_COUNT_EN
      tx_count_q <= tx_count_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
    scl_prev_d = scl_s;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nack_d     = nack_q;
    underrun_d = underrun_q;
    tx_load_c  = 1'b0;
    load_word  = 1'b0;
`ifdef TX_BYTE_COUNT_EN
    tx_count_d = tx_count_q;
`endif

    if (bus.i2c_stop) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          state_d    = S_LOAD;
          nack_d     = 1'b0;
          underrun_d = 1'b0;
`ifdef TX_BYTE_COUNT_EN
          tx_count_d = '0;
`endif
        end
        S_LOAD: begin
          load_word = 1'b1;
          state_d   = S_SHIFT;
        end
        S_SHIFT: if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = S_ACK;
          end else begin
            shift_d   = {shift_q[DW-2:0], 1'b1};
            sda_oe_d  = ~shift_q[DW-2];
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        S_ACK: if (scl_rise) begin
          if (!sda_s) begin
            state_d = S_ACK_END;
`ifdef TX_BYTE_COUNT_EN
            if (tx_count_q != 16'hFFFF) tx_count_d = tx_count_q + 16'd1;
`endif
          end else begin
            nack_d  = 1'b1;
            state_d = S_WAIT_STOP;
          end
        end
        S_ACK_END: if (scl_fall) begin
          state_d   = S_SHIFT;
          bit_cnt_d = 3'd7;
          // Last byte of the word: fetch the next word in this same cycle.
          if (byte_cnt_q == BCW'(WORD_BYTES - 1)) begin
            load_word = 1'b1;
          end else begin
            shift_d    = {shift_q[DW-2:0], 1'b1};
            sda_oe_d   = ~shift_q[DW-2];
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        S_WAIT_STOP: sda_oe_d = 1'b0;
        default:     state_d  = S_IDLE;
      endcase
    end

    if (load_word) begin
      byte_cnt_d = '0;
      bit_cnt_d  = 3'd7;
      if (bus.tx_valid) begin
        shift_d   = bus.tx_data;
        sda_oe_d  = ~bus.tx_data[DW-1];
        tx_load_c = 1'b1;
      end else begin
        shift_d    = '1;
        sda_oe_d   = 1'b0;
        underrun_d = 1'b1;
      end
    end
  end

  assign bus.tx_load   = tx_load_c;
  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.nack_rcvd = nack_q;
  assign bus.underrun  = underrun_q;
`ifdef TX_BYTE_COUNT_EN
  assign bus.tx_count  = tx_count_q;
`endif
endmodule

// File: tb/tb_i2c_tx_shifter.sv
// Directed bench for i2c_tx_shifter: table of read transactions plus stop/reset corner sequences.
module tb_i2c_tx_shifter;
  localparam int HALF = 12;

  logic clk;
  logic n_rst;
  logic scl;
  logic m_low;

  i2c_tx_shifter_if #(.WORD_BYTES(8)) bus ();

  i2c_tx_shifter #(.WORD_BYTES(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream word source: small ring, popped when tx_load is seen.
  logic [63:0] words [4];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  int          load_cnt = 0;
  int          oe_hi_cnt = 0;
  logic        oe_was = 1'b0;
  logic        scl_was = 1'b1;

  assign bus.scl_in   = scl;
  assign bus.sda_in   = ~(bus.sda_oe | m_low);
  assign bus.tx_valid = (rd_ptr != wr_ptr);
  assign bus.tx_data  = words[rd_ptr[1:0]];

  always @(negedge clk) begin
    if (bus.tx_load) begin
      load_cnt = load_cnt + 1;
      @(posedge clk);
      #1 rd_ptr = rd_ptr + 1;
    end
  end

  // Counts sda_oe changes while SCL is held high.
  always @(posedge clk) begin
    #2;
    if (n_rst && scl && scl_was && (bus.sda_oe !== oe_was)) oe_hi_cnt = oe_hi_cnt + 1;
    oe_was  = bus.sda_oe;
    scl_was = scl;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_stop();
    bus.i2c_stop = 1'b1;
    @(negedge clk);
    bus.i2c_stop = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic scl_pulse(input logic stop_hi, output logic line);
    clk_wait(HALF);
    scl = 1'b1;
    clk_wait(HALF / 2);
    line = bus.sda_in;
    if (stop_hi) pulse_stop();
    clk_wait(HALF / 2);
    scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, input logic stop_after, output logic [7:0] b);
    logic bit_v;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      scl_pulse(1'b0, bit_v);
      b = {b[6:0], bit_v};
    end
    m_low = ~nack;
    scl_pulse(stop_after, bit_v);
    m_low = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] w);
    words[wr_ptr[1:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  typedef struct {
    string       name;
    int          nwords;
    logic [63:0] w0;
    logic [63:0] w1;
    int          nbytes;
    logic        nack_last;
    logic [127:0] exp;
    logic        exp_nack;
    logic        exp_under;
    int          exp_loads;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          loads0;
    int          oe0;
    logic [7:0]  got;
    logic [7:0]  want;
    logic        line;
    logic        released;

    vecs[0] = '{"ack8",  1, 64'h0123456789ABCDEF, 64'h0, 8,  1'b0,
                {64'h0123456789ABCDEF, 64'h0}, 1'b0, 1'b0, 1};
    vecs[1] = '{"nack3", 1, 64'h0123456789ABCDEF, 64'h0, 3,  1'b1,
                {64'h0123450000000000, 64'h0}, 1'b1, 1'b0, 1};
    vecs[2] = '{"under", 0, 64'h0, 64'h0, 2,  1'b0,
                {16'hFFFF, 112'h0}, 1'b0, 1'b1, 0};
    vecs[3] = '{"clr",   1, 64'hC300000000000000, 64'h0, 1,  1'b1,
                {8'hC3, 120'h0}, 1'b1, 1'b0, 1};
    vecs[4] = '{"two",   2, 64'hFFFF0000FFFF0000, 64'h00000000000000A5, 16, 1'b0,
                {64'hFFFF0000FFFF0000, 64'h00000000000000A5}, 1'b0, 1'b0, 2};

    n_rst = 1'b0;
    scl = 1'b1;
    m_low = 1'b0;
    bus.start = 1'b0;
    bus.i2c_stop = 1'b0;
    clk_wait(3);
    check("rst_sda_oe",  {63'h0, bus.sda_oe},    64'h0);
    check("rst_busy",    {63'h0, bus.busy},      64'h0);
    check("rst_tx_load", {63'h0, bus.tx_load},   64'h0);
    check("rst_nack",    {63'h0, bus.nack_rcvd}, 64'h0);
    check("rst_under",   {63'h0, bus.underrun},  64'h0);
`ifdef TX_BYTE_COUNT_EN
    check("rst_count",   {48'h0, bus.tx_count},  64'h0);
`endif
    n_rst = 1'b1;
    clk_wait(2);
    scl = 1'b0;
    clk_wait(5);

    for (int v = 0; v < 5; v++) begin
      wr_ptr = rd_ptr;
      if (vecs[v].nwords > 0) push_word(vecs[v].w0);
      if (vecs[v].nwords > 1) push_word(vecs[v].w1);
      loads0 = load_cnt;
      oe0 = oe_hi_cnt;
      do_start();
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        logic last;
        last = (b == vecs[v].nbytes - 1);
        read_byte(last & vecs[v].nack_last, last & ~vecs[v].nack_last, got);
        want = vecs[v].exp[127 - 8*b -: 8];
        check($sformatf("%s_byte%0d", vecs[v].name, b), {56'h0, got}, {56'h0, want});
      end
      if (vecs[v].nack_last) begin
        released = 1'b1;
        for (int p = 0; p < 9; p++) begin
          scl_pulse(1'b0, line);
          if (!line || bus.sda_oe) released = 1'b0;
        end
        check({vecs[v].name, "_released"}, {63'h0, released}, 64'h1);
        clk_wait(4);
        pulse_stop();
      end
      clk_wait(3);
      check({vecs[v].name, "_busy"},  {63'h0, bus.busy},      64'h0);
      check({vecs[v].name, "_nack"},  {63'h0, bus.nack_rcvd}, {63'h0, vecs[v].exp_nack});
      check({vecs[v].name, "_under"}, {63'h0, bus.underrun},  {63'h0, vecs[v].exp_under});
      check({vecs[v].name, "_loads"}, 64'(load_cnt - loads0), 64'(vecs[v].exp_loads));
      check({vecs[v].name, "_oe_hi"}, 64'(oe_hi_cnt - oe0),   64'h0);
      clk_wait(5);
    end

    // STOP while bit 4 of byte 2 is being driven low.
    wr_ptr = rd_ptr;
    push_word(64'h5A00000000000000);
    do_start();
    read_byte(1'b0, 1'b0, got);
    check("mid_byte1", {56'h0, got}, 64'h5A);
    for (int p = 0; p < 3; p++) scl_pulse(1'b0, line);
    clk_wait(6);
    check("mid_bit4_drive", {63'h0, bus.sda_oe}, 64'h1);
    pulse_stop();
    check("mid_stop_oe",   {63'h0, bus.sda_oe}, 64'h0);
    check("mid_stop_busy", {63'h0, bus.busy},   64'h0);
    clk_wait(5);

    // Asynchronous reset mid-byte of a new transfer.
    wr_ptr = rd_ptr;
    push_word(64'h0000000000000000);
    do_start();
    for (int p = 0; p < 2; p++) scl_pulse(1'b0, line);
    clk_wait(6);
    check("ar_drive", {63'h0, bus.sda_oe}, 64'h1);
    #3 n_rst = 1'b0;
    #1;
    check("ar_sda_oe",  {63'h0, bus.sda_oe},    64'h0);
    check("ar_busy",    {63'h0, bus.busy},      64'h0);
    check("ar_tx_load", {63'h0, bus.tx_load},   64'h0);
    check("ar_nack",    {63'h0, bus.nack_rcvd}, 64'h0);
    check("ar_under",   {63'h0, bus.underrun},  64'h0);
    @(negedge clk);
    clk_wait(2);
    check("ar_hold_oe", {63'h0, bus.sda_oe}, 64'h0);
    n_rst = 1'b1;
    clk_wait(5);

`ifdef TX_BYTE_COUNT_EN
    wr_ptr = rd_ptr;
    push_word(64'h0123456789ABCDEF);
    do_start();
    for (int b = 0; b < 6; b++) read_byte(b == 5, 1'b0, got);
    clk_wait(3);
    check("cnt_after_nack", {48'h0, bus.tx_count}, 64'd5);
    pulse_stop();
    clk_wait(3);
    do_start();
    clk_wait(2);
    check("cnt_cleared", {48'h0, bus.tx_count}, 64'd0);
    pulse_stop();
    clk_wait(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end
endmodule
